// File: rtl/riscv_pkg.sv
// Shared types and constants for the fetch front end.
package riscv_pkg;

    localparam int unsigned XLEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_FLUSH
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetched {pc, instr} entries with flush and occupancy count.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PtrW = $clog2(DEPTH),
    localparam int unsigned CntW = PtrW + 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            clear_i,
    input  logic            push_i,
    input  fetch_entry_t    data_i,
    input  logic            pop_i,
    output fetch_entry_t    data_o,
    output logic            empty_o,
    output logic [CntW-1:0] count_o
);

    fetch_entry_t    mem_q [DEPTH];
    logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            full, do_pop;

    assign full    = (cnt_q == CntW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign data_o  = mem_q[rptr_q];
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (clear_i) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (push_i) wptr_d = wptr_q + PtrW'(1);
            if (do_pop) rptr_d = rptr_q + PtrW'(1);
            if (push_i && !do_pop) cnt_d = cnt_q + CntW'(1);
            else if (!push_i && do_pop) cnt_d = cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i && !clear_i) mem_q[wptr_q] <= data_i;
    end

    // Upstream credit accounting must make this impossible.
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push_i && full && !clear_i));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues imem fetches, buffers words for decode.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter int unsigned     XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned     FIFO_DEPTH = 2
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    output logic            imem_req_valid_o,
    input  logic            imem_req_ready_i,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_rsp_valid_i,
    input  logic [31:0]     imem_rsp_data_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            inst_valid_o,
    input  logic            inst_ready_i,
    output logic [31:0]     instruction_o,
    output logic [XLEN-1:0] pc_o
);

    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d, redir_pc;
    logic [CntW-1:0] outst_q, outst_d, drop_q, drop_d, fifo_cnt;
    logic [CntW:0]   credit_used;
    logic            req_fire, push, pop, fifo_empty;
    fetch_entry_t    push_entry, head;
    logic            unused_redir_lsb;

    assign unused_redir_lsb = ^redirect_pc_i[1:0];
    assign redir_pc         = {redirect_pc_i[XLEN-1:2], 2'b00};
    assign credit_used      = {1'b0, outst_q} + {1'b0, fifo_cnt};

    assign imem_req_valid_o = (state_q == S_RUN) && !redirect_i &&
                              (credit_used < (CntW + 1)'(FIFO_DEPTH));
    assign imem_addr_o      = fetch_pc_q;
    assign req_fire         = imem_req_valid_o && imem_req_ready_i;

    // Responses are only kept in S_RUN; in S_FLUSH or a redirect cycle they are stale.
    assign push             = imem_rsp_valid_i && (state_q == S_RUN) && !redirect_i;
    assign push_entry.pc    = resp_pc_q;
    assign push_entry.instr = imem_rsp_data_i;
    assign pop              = inst_valid_o && inst_ready_i && !redirect_i;

    assign inst_valid_o  = !fifo_empty;
    assign instruction_o = inst_valid_o ? head.instr : NOP_INSTR;
    assign pc_o          = inst_valid_o ? head.pc : resp_pc_q;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        outst_d    = outst_q;
        drop_d     = drop_q;

        if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(4);
        if (push) resp_pc_d = resp_pc_q + XLEN'(4);

        if (req_fire && !imem_rsp_valid_i) outst_d = outst_q + CntW'(1);
        else if (!req_fire && imem_rsp_valid_i) outst_d = outst_q - CntW'(1);

        if (redirect_i) begin
            fetch_pc_d = redir_pc;
            resp_pc_d  = redir_pc;
            drop_d     = outst_d;
        end else if (imem_rsp_valid_i && drop_q != '0) begin
            drop_d = drop_q - CntW'(1);
        end

        unique case (state_q)
            S_BOOT:  state_d = S_RUN;
            S_RUN:   if (drop_d != '0) state_d = S_FLUSH;
            S_FLUSH: if (drop_d == '0) state_d = S_RUN;
            default: state_d = S_BOOT;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= S_BOOT;
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            outst_q    <= '0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (redirect_i),
        .push_i  (push),
        .data_i  (push_entry),
        .pop_i   (pop),
        .data_o  (head),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: imem model, decode-side scoreboard, corner sequences.
module tb_fetch_unit;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_ni, req_valid, req_ready, rsp_valid, redirect, inst_valid, inst_ready;
    logic [31:0] addr, rsp_data, redirect_pc, instr, pc;

    always #5 clk = ~clk;

    fetch_unit #(
        .XLEN       (32),
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .imem_req_valid_o (req_valid),
        .imem_req_ready_i (req_ready),
        .imem_addr_o      (addr),
        .imem_rsp_valid_i (rsp_valid),
        .imem_rsp_data_i  (rsp_data),
        .redirect_i       (redirect),
        .redirect_pc_i    (redirect_pc),
        .inst_valid_o     (inst_valid),
        .inst_ready_i     (inst_ready),
        .instruction_o    (instr),
        .pc_o             (pc)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;
    typedef struct {
        logic        rq_rdy;
        logic        in_rdy;
        logic        e_rv;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_pc;
    } vec_t;

    pend_t       pending[$];
    exp_t        exp_q[$];
    logic [31:0] iss_q[$];
    vec_t        vecs[7];
    int          checks = 0, failures = 0, cyc = 0, lat = 1, n_cons = 0;
    logic        rsp_now, fire_req;
    logic [31:0] fire_addr, saved_pc, saved_instr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic expect_seq(input logic [31:0] start, input int n);
        logic [31:0] p;
        p = start;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{pc: p, instr: mem_word(p)});
            p = p + 32'd4;
        end
    endtask

    // Drive imem response for this cycle, then sample at the falling edge.
    task automatic drive_sample();
        exp_t e;
        rsp_now   = rst_ni && pending.size() > 0 && pending[0].due <= cyc;
        rsp_valid = rsp_now;
        rsp_data  = rsp_now ? mem_word(pending[0].addr) : 32'h0;
        @(negedge clk);
        fire_req  = req_valid && req_ready;
        fire_addr = addr;
        if (rst_ni && inst_valid && inst_ready && !redirect) begin
            n_cons++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_empty: got pc %h expected no instruction", pc);
            end else begin
                e = exp_q.pop_front();
                chk("sb_pc", pc, e.pc);
                chk("sb_instr", instr, e.instr);
            end
        end
    endtask

    task automatic finish_cycle();
        @(posedge clk);
        #1;
        if (!rst_ni) begin
            pending.delete();
        end else begin
            if (rsp_now) void'(pending.pop_front());
            if (fire_req) begin
                pending.push_back('{addr: fire_addr, due: cyc + lat});
                iss_q.push_back(fire_addr);
            end
        end
        cyc++;
    endtask

    task automatic cycle();
        drive_sample();
        finish_cycle();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_valid"}, {31'h0, req_valid}, 32'h0);
        chk({tag, "_addr"}, addr, 32'h0);
        chk({tag, "_inst_valid"}, {31'h0, inst_valid}, 32'h0);
        chk({tag, "_instr"}, instr, NOP_INSTR);
        chk({tag, "_pc"}, pc, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int start;
        rst_ni = 1'b0; req_ready = 1'b1; inst_ready = 1'b1; redirect = 1'b0;
        redirect_pc = 32'h0; rsp_valid = 1'b0; rsp_data = 32'h0;

        // Cycle-exact stream after boot: registered credit limit of 2 gives 2 of 3 cycles.
        vecs[0] = '{1'b1, 1'b1, 1'b1, 32'h0,  1'b0, 32'h0};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 32'h4,  1'b0, 32'h0};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 32'h8,  1'b1, 32'h0};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 32'h8,  1'b1, 32'h4};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 32'hC,  1'b0, 32'h0};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 32'h10, 1'b1, 32'h8};
        vecs[6] = '{1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'hC};

        cycle();
        cycle();
        check_reset_outputs("reset");
        rst_ni = 1'b1;
        expect_seq(32'h0, 400);
        drive_sample();
        chk("boot_req_valid", {31'h0, req_valid}, 32'h0);
        finish_cycle();

        for (int i = 0; i < 7; i++) begin
            req_ready  = vecs[i].rq_rdy;
            inst_ready = vecs[i].in_rdy;
            drive_sample();
            chk($sformatf("vec%0d_req_valid", i), {31'h0, req_valid}, {31'h0, vecs[i].e_rv});
            chk($sformatf("vec%0d_addr", i), addr, vecs[i].e_addr);
            chk($sformatf("vec%0d_inst_valid", i), {31'h0, inst_valid}, {31'h0, vecs[i].e_iv});
            if (vecs[i].e_iv) chk($sformatf("vec%0d_pc", i), pc, vecs[i].e_pc);
            else chk($sformatf("vec%0d_nop", i), instr, NOP_INSTR);
            finish_cycle();
        end

        // Decode stall: outputs hold, requests stop once credits are used up.
        for (int i = 0; i < 10 && !inst_valid; i++) cycle();
        inst_ready = 1'b0;
        drive_sample();
        saved_pc    = pc;
        saved_instr = instr;
        finish_cycle();
        for (int i = 0; i < 4; i++) begin
            drive_sample();
            chk("stall_valid", {31'h0, inst_valid}, 32'h1);
            chk("stall_pc", pc, saved_pc);
            chk("stall_instr", instr, saved_instr);
            if (i == 3) chk("stall_req_valid", {31'h0, req_valid}, 32'h0);
            finish_cycle();
        end
        inst_ready = 1'b1;
        repeat (12) cycle();

        // Random backpressure with 3-cycle imem latency.
        lat   = 3;
        start = n_cons;
        for (int i = 0; i < 80; i++) begin
            req_ready  = 1'($urandom_range(0, 1));
            inst_ready = ($urandom_range(0, 3) != 0);
            drive_sample();
            chk("inflight_le_depth", {31'h0, pending.size() <= 2}, 32'h1);
            finish_cycle();
        end
        chk("random_progress", {31'h0, n_cons > start + 10}, 32'h1);

        // Redirect with two fetches in flight: both responses must be dropped.
        req_ready = 1'b1;
        inst_ready = 1'b1;
        for (int i = 0; i < 20 && pending.size() != 2; i++) cycle();
        chk("reach_two_outstanding", pending.size(), 32'd2);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0103;
        expect_seq(32'h0000_0100, 100);
        iss_q.delete();
        drive_sample();
        chk("redir_req_valid", {31'h0, req_valid}, 32'h0);
        finish_cycle();
        redirect = 1'b0;
        for (int i = 0; i < 10 && pending.size() > 0; i++) begin
            drive_sample();
            chk("flush_req_valid", {31'h0, req_valid}, 32'h0);
            chk("flush_inst_valid", {31'h0, inst_valid}, 32'h0);
            finish_cycle();
        end
        start = n_cons;
        for (int i = 0; i < 12 && n_cons == start; i++) cycle();
        chk("redir_consumed", {31'h0, n_cons > start}, 32'h1);
        chk("redir_first_addr", (iss_q.size() > 0) ? iss_q[0] : 32'hFFFF_FFFF, 32'h0000_0100);
        repeat (6) cycle();

        // Redirect coinciding with a response and a decode pop.
        lat = 1;
        for (int i = 0; i < 20; i++) begin
            if (pending.size() > 0 && pending[0].due <= cyc && inst_valid) break;
            cycle();
        end
        chk("coincide_found", {31'h0, pending.size() > 0 && inst_valid}, 32'h1);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        expect_seq(32'h0000_0200, 100);
        drive_sample();
        chk("coincide_rsp", {31'h0, rsp_valid}, 32'h1);
        chk("coincide_req_valid", {31'h0, req_valid}, 32'h0);
        finish_cycle();
        redirect = 1'b0;
        chk("coincide_fifo_empty", {31'h0, inst_valid}, 32'h0);
        repeat (10) cycle();

        // PC wrap at the top of the address space.
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        expect_seq(32'hFFFF_FFFC, 100);
        cycle();
        redirect = 1'b0;
        iss_q.delete();
        for (int i = 0; i < 12 && iss_q.size() < 2; i++) cycle();
        chk("wrap_addr0", (iss_q.size() > 0) ? iss_q[0] : 32'h1, 32'hFFFF_FFFC);
        chk("wrap_addr1", (iss_q.size() > 1) ? iss_q[1] : 32'h1, 32'h0000_0000);
        repeat (6) cycle();

        // Reset mid-stream.
        rst_ni = 1'b0;
        cycle();
        check_reset_outputs("midreset");
        rst_ni = 1'b1;
        expect_seq(32'h0, 100);
        iss_q.delete();
        start = n_cons;
        repeat (10) cycle();
        chk("post_reset_addr", (iss_q.size() > 0) ? iss_q[0] : 32'h1, 32'h0);
        chk("post_reset_progress", {31'h0, n_cons > start}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
